// File: rtl/pn_pkg.sv
// Shared flit field positions and the priority comparison used by every comparator.
// Golden-flit priority is compiled in with PN_GOLDEN_EN.
package pn_pkg;
    localparam int WIDTH_DATA     = 32;
    localparam int WIDTH_INTERNAL = WIDTH_DATA + 32;
    localparam int AGE_LO         = WIDTH_DATA + 8;
    localparam int AGE_HI         = WIDTH_DATA + 15;
    localparam int GOLDEN_BIT     = WIDTH_DATA + 31;

    // Sort key is {golden, age}; the input index rides along so equal keys keep input order.
    localparam int KEY_W = 9;
    localparam int IDX_W = 2;
    localparam int TAG_W = KEY_W + IDX_W;

    function automatic logic pn_higher(
        input logic [KEY_W-1:0] a_key,
        input logic [IDX_W-1:0] a_idx,
        input logic [KEY_W-1:0] b_key,
        input logic [IDX_W-1:0] b_idx
    );
        return (a_key > b_key) || ((a_key == b_key) && (a_idx < b_idx));
    endfunction
endpackage

// File: rtl/pn_swap2.sv
// 2x2 compare-and-swap on tagged words {key, idx, flit}; higher priority exits on o_hi.
// Purely combinational.
module pn_swap2
    import pn_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH+TAG_W-1:0] i_a,
    input  logic [WIDTH+TAG_W-1:0] i_b,
    output logic [WIDTH+TAG_W-1:0] o_hi,
    output logic [WIDTH+TAG_W-1:0] o_lo
);
    logic w_b_first;

    assign w_b_first = pn_higher(i_b[WIDTH+TAG_W-1 -: KEY_W], i_b[WIDTH+IDX_W-1 -: IDX_W],
                                 i_a[WIDTH+TAG_W-1 -: KEY_W], i_a[WIDTH+IDX_W-1 -: IDX_W]);

    assign o_hi = w_b_first ? i_b : i_a;
    assign o_lo = w_b_first ? i_a : i_b;
endmodule

// File: rtl/permutation_network.sv
// 4-flit priority sorter: 5-comparator network, registered outputs, one-cycle latency.
// Define PN_GOLDEN_EN to let flags[2] (golden) outrank age.
module permutation_network
    import pn_pkg::*;
#(
    parameter int WIDTH_DATA     = 32,
    parameter int WIDTH_INTERNAL = WIDTH_DATA + 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH_INTERNAL-1:0] din0,
    input  logic [WIDTH_INTERNAL-1:0] din1,
    input  logic [WIDTH_INTERNAL-1:0] din2,
    input  logic [WIDTH_INTERNAL-1:0] din3,
    output logic [WIDTH_INTERNAL-1:0] dout0,
    output logic [WIDTH_INTERNAL-1:0] dout1,
    output logic [WIDTH_INTERNAL-1:0] dout2,
    output logic [WIDTH_INTERNAL-1:0] dout3
);
    localparam int TW     = WIDTH_INTERNAL + TAG_W;
    localparam int AGE_L  = AGE_LO - pn_pkg::WIDTH_DATA + WIDTH_DATA;
    localparam int AGE_H  = AGE_HI - pn_pkg::WIDTH_DATA + WIDTH_DATA;
    localparam int GOLD_L = GOLDEN_BIT - pn_pkg::WIDTH_DATA + WIDTH_DATA;
`ifdef PN_GOLDEN_EN
    localparam bit GOLDEN_ON = 1'b1;
`else
    localparam bit GOLDEN_ON = 1'b0;
`endif

    logic [WIDTH_INTERNAL-1:0] w_din  [4];
    logic [TW-1:0]             w_in   [4];
    logic [TW-1:0]             w_s1   [4];
    logic [TW-1:0]             w_s2   [4];
    logic [TW-1:0]             w_s3   [4];
    logic [WIDTH_INTERNAL-1:0] r_dout [4];
    logic                      w_unused_tags;

    assign w_din[0] = din0;
    assign w_din[1] = din1;
    assign w_din[2] = din2;
    assign w_din[3] = din3;

    for (genvar g = 0; g < 4; g++) begin : g_tag
        assign w_in[g] = {GOLDEN_ON & w_din[g][GOLD_L], w_din[g][AGE_H:AGE_L],
                          IDX_W'(g), w_din[g]};
    end

    pn_swap2 #(.WIDTH(WIDTH_INTERNAL)) u_s1a (.i_a(w_in[0]), .i_b(w_in[1]), .o_hi(w_s1[0]), .o_lo(w_s1[1]));
    pn_swap2 #(.WIDTH(WIDTH_INTERNAL)) u_s1b (.i_a(w_in[2]), .i_b(w_in[3]), .o_hi(w_s1[2]), .o_lo(w_s1[3]));
    pn_swap2 #(.WIDTH(WIDTH_INTERNAL)) u_s2a (.i_a(w_s1[0]), .i_b(w_s1[2]), .o_hi(w_s2[0]), .o_lo(w_s2[2]));
    pn_swap2 #(.WIDTH(WIDTH_INTERNAL)) u_s2b (.i_a(w_s1[1]), .i_b(w_s1[3]), .o_hi(w_s2[1]), .o_lo(w_s2[3]));
    pn_swap2 #(.WIDTH(WIDTH_INTERNAL)) u_s3  (.i_a(w_s2[1]), .i_b(w_s2[2]), .o_hi(w_s3[1]), .o_lo(w_s3[2]));

    assign w_s3[0] = w_s2[0];
    assign w_s3[3] = w_s2[3];

    // Tags only steer the network; they are dropped at the output register.
    assign w_unused_tags = ^{w_s3[0][TW-1:WIDTH_INTERNAL], w_s3[1][TW-1:WIDTH_INTERNAL],
                             w_s3[2][TW-1:WIDTH_INTERNAL], w_s3[3][TW-1:WIDTH_INTERNAL]};

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) r_dout[k] <= '0;
            else       r_dout[k] <= w_s3[k][WIDTH_INTERNAL-1:0];
        end
    end

    assign dout0 = r_dout[0];
    assign dout1 = r_dout[1];
    assign dout2 = r_dout[2];
    assign dout3 = r_dout[3];
endmodule

// File: tb/tb_permutation_network.sv
// Directed and randomized bench for permutation_network; reference is a stable insertion sort.
module tb_permutation_network;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din [4];
    logic [63:0] dout0, dout1, dout2, dout3;
    logic [63:0] dq [4];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    permutation_network dut (
        .clk(clk), .reset(reset),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3)
    );

    always #5 clk = ~clk;

    assign dq[0] = dout0;
    assign dq[1] = dout1;
    assign dq[2] = dout2;
    assign dq[3] = dout3;

    function automatic logic [63:0] mk(input logic [7:0] age, input logic [31:0] data);
        return {16'h0, age, 8'h00, data};
    endfunction

    function automatic logic [8:0] key_of(input logic [63:0] f);
`ifdef PN_GOLDEN_EN
        return {f[63], f[47:40]};
`else
        return {1'b0, f[47:40]};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic apply(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
        @(negedge clk);
        din[0] = a; din[1] = b; din[2] = c; din[3] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
        check({tag, "_d0"}, dq[0], e0);
        check({tag, "_d1"}, dq[1], e1);
        check({tag, "_d2"}, dq[2], e2);
        check({tag, "_d3"}, dq[3], e3);
    endtask

    task automatic check_model(input string tag);
        int ord [4];
        int t;
        for (int i = 0; i < 4; i++) ord[i] = i;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (key_of(din[ord[j]]) > key_of(din[ord[j-1]])) begin
                    t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
                end
            end
        end
        expect4(tag, din[ord[0]], din[ord[1]], din[ord[2]], din[ord[3]]);
`ifndef PN_GOLDEN_EN
        for (int k = 0; k < 3; k++)
            check({tag, "_age_order"}, 64'(dq[k][47:40] >= dq[k+1][47:40]), 64'd1);
`endif
    endtask

    initial begin
        logic [63:0] fa, fb, fc, fd, rv;
        reset = 1'b1;
        din[0] = 64'h1111_0F00_0000_0001; din[1] = 64'h2222_2000_0000_0002;
        din[2] = 64'h3333_3000_0000_0003; din[3] = 64'h4444_4000_0000_0004;
        @(posedge clk); #1;
        expect4("reset", 64'h0, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        fa = mk(8'd15, 32'hA); fb = mk(8'd14, 32'hB); fc = mk(8'd13, 32'hC); fd = mk(8'd12, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("desc", fa, fb, fc, fd);

        fa = mk(8'd10, 32'hA); fb = mk(8'd11, 32'hB); fc = mk(8'd12, 32'hC); fd = mk(8'd13, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("asc", fd, fc, fb, fa);

        fa = mk(8'd10, 32'hA); fb = mk(8'd5, 32'hB); fc = mk(8'd9, 32'hC); fd = mk(8'd18, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("mixed", fd, fa, fc, fb);

        fa = mk(8'd7, 32'hA); fb = mk(8'd7, 32'hB); fc = mk(8'd7, 32'hC); fd = mk(8'd7, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("equal", fa, fb, fc, fd);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        expect4("reset2", 64'h0, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Ties across comparator groups: stage-3 tie where a later input reached slot 1 first.
        fa = mk(8'd7, 32'hA); fb = mk(8'd1, 32'hB); fc = mk(8'd9, 32'hC); fd = mk(8'd7, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("cross_tie", fc, fa, fd, fb);

        fa = mk(8'hFF, 32'hA); fb = mk(8'h00, 32'hB); fc = mk(8'h80, 32'hC); fd = mk(8'h01, 32'hD);
        apply(fa, fb, fc, fd);
        expect4("extremes", fa, fc, fd, fb);

        apply(64'h0, 64'h0, 64'h0, 64'h0);
        expect4("idle", 64'h0, 64'h0, 64'h0, 64'h0);

`ifdef PN_GOLDEN_EN
        fa = mk(8'd50, 32'hA); fb = mk(8'd40, 32'hB); fc = mk(8'd30, 32'hC);
        fd = mk(8'd0, 32'hD) | (64'h1 << 63);
        apply(fa, fb, fc, fd);
        expect4("golden", fd, fa, fb, fc);
`endif

        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rv = {$urandom, $urandom};
                if (v % 2 == 0) rv[47:40] = 8'($urandom_range(0, 3));
                din[i] = rv;
            end
            @(posedge clk); #1;
            check_model($sformatf("rand%0d", v));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
